// File: rtl/mod_seq_checker.sv
// Sequence checker for a mod-N counter bus: locks onto a clean +1 mod N sequence,
// then flags broken steps, out-of-range codes and wraps, and keeps error/wrap totals.
module mod_seq_checker #(
    parameter int N        = 30,
    parameter int WIDTH    = 5,
    parameter int LOCK_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             seq_err,
    output logic             range_err,
    output logic             wrap,
    output logic [7:0]       err_count,
    output logic [15:0]      wrap_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LAST_CODE = WIDTH'(N - 1);
    localparam logic [3:0]       LOCK_CNT  = 4'(LOCK_LEN);

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev_q, prev_q_nx;
    logic [3:0]       good_cnt, good_cnt_nx;
    logic [3:0]       good_inc;
    logic             seq_err_nx, range_err_nx, wrap_nx;
    logic             err_inc, wrap_inc;
    logic             out_of_range;
    logic             step_ok;
    logic             prev_is_last;
    logic [WIDTH-1:0] expect_q;

    // Compare one bit wider so N == 2^WIDTH never reports a false range error.
    assign out_of_range = ({1'b0, q_in} >= (WIDTH + 1)'(N));
    assign prev_is_last = (prev_q == LAST_CODE);
    assign expect_q     = prev_is_last ? '0 : prev_q + 1'b1;
    assign step_ok      = (q_in == expect_q);
    assign good_inc     = good_cnt + 4'd1;

    always_comb begin
        state_nx     = state;
        prev_q_nx    = prev_q;
        good_cnt_nx  = good_cnt;
        seq_err_nx   = 1'b0;
        range_err_nx = 1'b0;
        wrap_nx      = 1'b0;
        err_inc      = 1'b0;
        wrap_inc     = 1'b0;

        if (en) begin
            unique case (state)
                IDLE: begin
                    if (out_of_range) begin
                        range_err_nx = 1'b1;
                        err_inc      = 1'b1;
                    end else begin
                        prev_q_nx   = q_in;
                        good_cnt_nx = '0;
                        state_nx    = ACQ;
                    end
                end

                ACQ: begin
                    if (out_of_range) begin
                        range_err_nx = 1'b1;
                        err_inc      = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        prev_q_nx = q_in;
                        if (step_ok) begin
                            good_cnt_nx = good_inc;
                            if (good_inc == LOCK_CNT) state_nx = LOCK;
                        end else begin
                            // A broken run while acquiring just restarts the count.
                            good_cnt_nx = '0;
                        end
                    end
                end

                LOCK: begin
                    if (out_of_range) begin
                        range_err_nx = 1'b1;
                        err_inc      = 1'b1;
                        state_nx     = IDLE;
                    end else if (step_ok) begin
                        prev_q_nx = q_in;
                        if (prev_is_last) begin
                            wrap_nx  = 1'b1;
                            wrap_inc = 1'b1;
                        end
                    end else begin
                        seq_err_nx  = 1'b1;
                        err_inc     = 1'b1;
                        prev_q_nx   = q_in;
                        good_cnt_nx = '0;
                        state_nx    = ACQ;
                    end
                end

                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_q     <= '0;
            good_cnt   <= '0;
            seq_err    <= 1'b0;
            range_err  <= 1'b0;
            wrap       <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            state     <= state_nx;
            prev_q    <= prev_q_nx;
            good_cnt  <= good_cnt_nx;
            seq_err   <= seq_err_nx;
            range_err <= range_err_nx;
            wrap      <= wrap_nx;
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
            if (wrap_inc) wrap_count <= wrap_count + 16'd1;
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_mod_seq_checker.sv
// Scoreboard bench for mod_seq_checker: stimulus pushes expected pulse events,
// a negedge monitor pops one per observed pulse and compares flags and counters.
module tb_mod_seq_checker;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [4:0]  q_in;
    logic        locked;
    logic        seq_err;
    logic        range_err;
    logic        wrap;
    logic [7:0]  err_count;
    logic [15:0] wrap_count;

    int checks = 0;
    int errors = 0;
    int exp_wc = 0;

    typedef struct {
        logic        s;
        logic        r;
        logic        w;
        logic        l;
        logic [7:0]  ec;
        logic [15:0] wc;
    } evt_t;

    evt_t exp_q[$];
    evt_t mon_e;

    mod_seq_checker #(.N(30), .WIDTH(5), .LOCK_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .q_in       (q_in),
        .locked     (locked),
        .seq_err    (seq_err),
        .range_err  (range_err),
        .wrap       (wrap),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic s, input logic r, input logic w, input logic l,
                        input int ec, input int wc);
        evt_t e;
        e.s  = s;
        e.r  = r;
        e.w  = w;
        e.l  = l;
        e.ec = 8'(ec);
        e.wc = 16'(wc);
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after an edge and are sampled on the next edge.
    task automatic tick(input int v, input logic e);
        q_in = 5'(v);
        en   = e;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (seq_err || range_err || wrap) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: seq=%0b range=%0b wrap=%0b, required none (t=%0t)",
                         seq_err, range_err, wrap, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("evt_seq_err",    32'(seq_err),    32'(mon_e.s));
                chk("evt_range_err",  32'(range_err),  32'(mon_e.r));
                chk("evt_wrap",       32'(wrap),       32'(mon_e.w));
                chk("evt_locked",     32'(locked),     32'(mon_e.l));
                chk("evt_err_count",  32'(err_count),  32'(mon_e.ec));
                chk("evt_wrap_count", 32'(wrap_count), 32'(mon_e.wc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        q_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked",     32'(locked),     32'd0);
        chk("rst_seq_err",    32'(seq_err),    32'd0);
        chk("rst_range_err",  32'(range_err),  32'd0);
        chk("rst_wrap",       32'(wrap),       32'd0);
        chk("rst_err_count",  32'(err_count),  32'd0);
        chk("rst_wrap_count", 32'(wrap_count), 32'd0);
        rst_n = 1'b1;

        // Free-running counter from 0: lock on edge 5, wrap on every 29->0 afterwards.
        for (int k = 1; k <= 500; k++) begin
            if (((k - 1) % 30 == 0) && k >= 6) begin
                exp_wc++;
                push(1'b0, 1'b0, 1'b1, 1'b1, 0, exp_wc);
            end
            tick((k - 1) % 30, 1'b1);
            if (k == 4) chk("lock_edge4", 32'(locked), 32'd0);
            if (k == 5) chk("lock_edge5", 32'(locked), 32'd1);
        end
        chk("run_err_count",  32'(err_count),  32'd0);
        chk("run_wrap_count", 32'(wrap_count), 32'd16);

        // Continue 20..29,0..12, then jump 12 -> 15.
        for (int v = 20; v <= 29; v++) tick(v, 1'b1);
        exp_wc++;
        push(1'b0, 1'b0, 1'b1, 1'b1, 0, exp_wc);
        for (int v = 0; v <= 12; v++) tick(v, 1'b1);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1, exp_wc);
        tick(15, 1'b1);
        chk("seq_unlock", 32'(locked), 32'd0);
        for (int v = 16; v <= 18; v++) tick(v, 1'b1);
        chk("relock_18", 32'(locked), 32'd0);
        tick(19, 1'b1);
        chk("relock_19", 32'(locked), 32'd1);

        // Out-of-range while locked: range error only, back to IDLE, 5 samples to relock.
        tick(20, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0, 2, exp_wc);
        tick(31, 1'b1);
        chk("range_unlock", 32'(locked), 32'd0);
        for (int v = 21; v <= 24; v++) tick(v, 1'b1);
        chk("range_relock_24", 32'(locked), 32'd0);
        tick(25, 1'b1);
        chk("range_relock_25", 32'(locked), 32'd1);

        // Pause with en low while the value holds at 7, resume at 8.
        for (int v = 26; v <= 29; v++) tick(v, 1'b1);
        exp_wc++;
        push(1'b0, 1'b0, 1'b1, 1'b1, 2, exp_wc);
        for (int v = 0; v <= 7; v++) tick(v, 1'b1);
        repeat (10) tick(7, 1'b0);
        chk("pause_locked", 32'(locked), 32'd1);
        tick(8, 1'b1);
        chk("resume_locked", 32'(locked), 32'd1);

        // A held value while enabled is a mismatch.
        push(1'b1, 1'b0, 1'b0, 1'b0, 3, exp_wc);
        tick(8, 1'b1);
        for (int v = 9; v <= 12; v++) tick(v, 1'b1);
        chk("pre_rst_locked",    32'(locked),    32'd1);
        chk("pre_rst_err_count", 32'(err_count), 32'd3);

        // Asynchronous reset between edges clears everything at once.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked",     32'(locked),     32'd0);
        chk("arst_err_count",  32'(err_count),  32'd0);
        chk("arst_wrap_count", 32'(wrap_count), 32'd0);
        chk("arst_pulses",     32'({seq_err, range_err, wrap}), 32'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Flood of out-of-range codes: counter saturates, flag keeps pulsing.
        for (int i = 1; i <= 300; i++) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, (i > 255) ? 255 : i, 0);
            tick((i % 2 == 1) ? 31 : 30, 1'b1);
        end
        tick(5, 1'b0);
        chk("sat_err_count",   32'(err_count), 32'd255);
        chk("pulse_clear_en0", 32'(range_err), 32'd0);
        chk("sat_locked",      32'(locked),    32'd0);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
